// File: rtl/y86_pkg.sv
// Shared Y86-64 register-file constants: register indices, the RNONE
// sentinel, the stack-pointer index, and a small claim-counting helper.
package y86_pkg;

    localparam logic [3:0] RRAX  = 4'h0;
    localparam logic [3:0] RRCX  = 4'h1;
    localparam logic [3:0] RRDX  = 4'h2;
    localparam logic [3:0] RRBX  = 4'h3;
    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] RRBP  = 4'h5;
    localparam logic [3:0] RRSI  = 4'h6;
    localparam logic [3:0] RRDI  = 4'h7;
    localparam logic [3:0] R8    = 4'h8;
    localparam logic [3:0] R9    = 4'h9;
    localparam logic [3:0] R10   = 4'ha;
    localparam logic [3:0] R11   = 4'hb;
    localparam logic [3:0] R12   = 4'hc;
    localparam logic [3:0] R13   = 4'hd;
    localparam logic [3:0] R14   = 4'he;
    localparam logic [3:0] RNONE = 4'hf;

    localparam int SP_IDX = 4;

    // Sum of two single-bit events, 0..2.
    function automatic logic [1:0] count2(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/sb_counter.sv
// Saturating outstanding-write counter: adds 0..2 claims and retires 0..2
// writes per cycle, flagging any overflow or underflow.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       inc_i,
    input  logic [1:0]       dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             err_o
);

    // Two guard bits: one for the +2 headroom, one as a sign for the -2 case.
    localparam int EW = CNT_W + 2;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [EW-1:0]    sum;
    logic             over, under;

    // NOTE: every comb output gets a default before any condition, so no latch is inferred.
    always_comb begin
        sum   = {2'b00, cnt_q} + EW'(inc_i) - EW'(dec_i);
        under = sum[EW-1];
        over  = ~sum[EW-1] & sum[CNT_W];
        cnt_d = sum[CNT_W-1:0];
        if (under) begin
            cnt_d = '0;
        end else if (over) begin
            cnt_d = '1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign err_o = over | under;

endmodule

// File: rtl/regfile_sb.sv
// Y86-64 register file with two write ports (M wins), optional write-through
// bypass, and a per-register scoreboard driving RAW hazard/stall outputs.
module regfile_sb #(
    parameter int               WIDTH    = 64,
    parameter int               AW       = 4,
    parameter int               NRD      = 2,
    parameter int               BYPASS   = 1,
    parameter int               CNT_W    = 2,
    parameter int               SP_IDX   = y86_pkg::SP_IDX,
    parameter logic [WIDTH-1:0] SP_RESET = '0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [AW-1:0]               dstE,
    input  logic [WIDTH-1:0]            valE,
    input  logic [AW-1:0]               dstM,
    input  logic [WIDTH-1:0]            valM,
    input  logic [NRD*AW-1:0]           src,
    output logic [NRD*WIDTH-1:0]        val,
    input  logic                        issue_valid,
    input  logic [AW-1:0]               issue_dstE,
    input  logic [AW-1:0]               issue_dstM,
    output logic [NRD-1:0]              hazard,
    output logic                        stall,
    output logic                        sb_err,
    output logic [(2**AW-1)*WIDTH-1:0]  regs
);

    import y86_pkg::*;

    localparam int              NREG      = 2**AW - 1;
    localparam logic [AW-1:0]   ADDR_NONE = '1;

    logic [WIDTH-1:0] rf_q [NREG];
    logic [WIDTH-1:0] rf_d [NREG];
    logic [1:0]       inc  [NREG];
    logic [1:0]       dec  [NREG];
    logic [CNT_W-1:0] cnt  [NREG];
    logic [NREG-1:0]  cnt_err;
    logic             sb_err_q, sb_err_d;
    logic [WIDTH-1:0] rd_val [NRD];
    logic [NRD-1:0]   haz;
    logic             bypass_en;

    assign bypass_en = (BYPASS != 0) && !reset;

    // RNONE is never a valid index, so it never matches a register here.
    always_comb begin
        rf_d = rf_q;
        for (int r = 0; r < NREG; r++) begin
            if (dstE == AW'(r)) rf_d[r] = valE;
            if (dstM == AW'(r)) rf_d[r] = valM;
        end
    end

    // NOTE: the register array is reset because decode must see defined values right after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                rf_q[r] <= (r == SP_IDX) ? SP_RESET : '0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_sb
        assign inc[g] = count2(issue_valid && (issue_dstE == AW'(g)),
                               issue_valid && (issue_dstM == AW'(g)));
        assign dec[g] = count2(dstE == AW'(g), dstM == AW'(g));

        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clock (clock),
            .reset (reset),
            .inc_i (inc[g]),
            .dec_i (dec[g]),
            .cnt_o (cnt[g]),
            .err_o (cnt_err[g])
        );
    end

    assign sb_err_d = sb_err_q | (|cnt_err);

    always_ff @(posedge clock) begin
        if (reset) begin
            sb_err_q <= 1'b0;
        end else begin
            sb_err_q <= sb_err_d;
        end
    end

    // With bypass, a claim retiring this cycle no longer blocks its reader.
    always_comb begin : read_ports
        logic [AW-1:0] rd_addr;
        for (int i = 0; i < NRD; i++) begin
            rd_addr   = src[i*AW +: AW];
            rd_val[i] = '0;
            haz[i]    = 1'b0;
            for (int r = 0; r < NREG; r++) begin
                if (rd_addr == AW'(r)) begin
                    rd_val[i] = rf_q[r];
                    if (BYPASS != 0) begin
                        haz[i] = {2'b00, cnt[r]} > {CNT_W'(0), dec[r]};
                    end else begin
                        haz[i] = cnt[r] != '0;
                    end
                end
            end
            if (bypass_en && rd_addr != ADDR_NONE) begin
                if (rd_addr == dstM) begin
                    rd_val[i] = valM;
                end else if (rd_addr == dstE) begin
                    rd_val[i] = valE;
                end
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_val
        assign val[i*WIDTH +: WIDTH] = rd_val[i];
    end

    for (genvar r = 0; r < NREG; r++) begin : g_regs
        assign regs[r*WIDTH +: WIDTH] = rf_q[r];
    end

    assign hazard = haz;
    assign stall  = |haz;
    assign sb_err = sb_err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a bypassing and a non-bypassing instance
// share one stimulus stream; expectations are hand-computed constants.
module tb_regfile_sb;

    import y86_pkg::*;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   dstE, dstM, issue_dstE, issue_dstM;
    logic [63:0]  valE, valM;
    logic [7:0]   src;
    logic         issue_valid;

    logic [127:0] val_b, val_n;
    logic [1:0]   hazard_b, hazard_n;
    logic         stall_b, stall_n, sb_err_b, sb_err_n;
    logic [959:0] regs_b, regs_n;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    regfile_sb #(.WIDTH(64), .AW(4), .NRD(2), .BYPASS(1), .CNT_W(2),
                 .SP_IDX(SP_IDX), .SP_RESET(64'h100)) dut_b (
        .clock(clock), .reset(reset),
        .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
        .src(src), .val(val_b),
        .issue_valid(issue_valid), .issue_dstE(issue_dstE), .issue_dstM(issue_dstM),
        .hazard(hazard_b), .stall(stall_b), .sb_err(sb_err_b), .regs(regs_b)
    );

    regfile_sb #(.WIDTH(64), .AW(4), .NRD(2), .BYPASS(0), .CNT_W(2),
                 .SP_IDX(SP_IDX), .SP_RESET(64'h0)) dut_n (
        .clock(clock), .reset(reset),
        .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
        .src(src), .val(val_n),
        .issue_valid(issue_valid), .issue_dstE(issue_dstE), .issue_dstM(issue_dstM),
        .hazard(hazard_n), .stall(stall_n), .sb_err(sb_err_n), .regs(regs_n)
    );

    typedef struct {
        logic        iv;
        logic [3:0]  ie, im, de;
        logic [63:0] ve;
        logic [3:0]  dm;
        logic [63:0] vm;
        logic [3:0]  s0, s1;
        logic [63:0] b0, b1;
        logic [1:0]  hb;
        logic [63:0] n0;
        logic [1:0]  hn;
        logic        err;
    } vec_t;

    vec_t vt [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        dstE        = RNONE;
        valE        = 64'h0;
        dstM        = RNONE;
        valM        = 64'h0;
        issue_valid = 1'b0;
        issue_dstE  = RNONE;
        issue_dstM  = RNONE;
        src         = {RNONE, RNONE};
    endtask

    task automatic do_reset();
        @(negedge clock);
        idle();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();

        //         iv    ie    im    de     ve        dm     vm     s0    s1     b0        b1        hb     n0        hn     err
        vt[0] = '{1'b1, RRBX, RRBX, RNONE, 64'h0,    RNONE, 64'h0, RRBX, RRSP,  64'h0,    64'h100,  2'b00, 64'h0,    2'b00, 1'b0};
        vt[1] = '{1'b0, RNONE,RNONE,RRBX,  64'h5,    RRBX,  64'h9, RRBX, RRDX,  64'h9,    64'h0,    2'b00, 64'h0,    2'b01, 1'b0};
        vt[2] = '{1'b1, RRDX, RNONE,RNONE, 64'h0,    RNONE, 64'h0, RRBX, RNONE, 64'h9,    64'h0,    2'b00, 64'h9,    2'b00, 1'b0};
        vt[3] = '{1'b1, RRCX, RNONE,RRDX,  64'hab,   RNONE, 64'h0, RRDX, RRBX,  64'hab,   64'h9,    2'b00, 64'h0,    2'b01, 1'b0};
        vt[4] = '{1'b0, RNONE,RNONE,RNONE, 64'h0,    RNONE, 64'h0, RRCX, RRDX,  64'h0,    64'hab,   2'b01, 64'h0,    2'b01, 1'b0};
        vt[5] = '{1'b0, RNONE,RNONE,RRCX,  64'h77,   RNONE, 64'h0, RRCX, RRCX,  64'h77,   64'h77,   2'b00, 64'h0,    2'b11, 1'b0};
        vt[6] = '{1'b0, RNONE,RNONE,RNONE, 64'h0,    RNONE, 64'h0, RRCX, RNONE, 64'h77,   64'h0,    2'b00, 64'h77,   2'b00, 1'b0};

        // Reset state.
        do_reset();
        #1;
        for (int r = 0; r < 15; r++) begin
            check($sformatf("rst.reg%0d", r), regs_b[r*64 +: 64],
                  (r == int'(RRSP)) ? 64'h100 : 64'h0);
        end
        check("rst.n_rsp", regs_n[int'(RRSP)*64 +: 64], 64'h0);
        check("rst.stall", 64'(stall_b), 64'h0);
        check("rst.sb_err", 64'(sb_err_b), 64'h0);

        // Priority, bypass and hazard lifecycle.
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            idle();
            issue_valid = vt[i].iv;
            issue_dstE  = vt[i].ie;
            issue_dstM  = vt[i].im;
            dstE        = vt[i].de;
            valE        = vt[i].ve;
            dstM        = vt[i].dm;
            valM        = vt[i].vm;
            src         = {vt[i].s1, vt[i].s0};
            #1;
            check($sformatf("v%0d.b_val0", i), val_b[63:0], vt[i].b0);
            check($sformatf("v%0d.b_val1", i), val_b[127:64], vt[i].b1);
            check($sformatf("v%0d.b_hazard", i), 64'(hazard_b), 64'(vt[i].hb));
            check($sformatf("v%0d.b_stall", i), 64'(stall_b), 64'(|vt[i].hb));
            check($sformatf("v%0d.n_val0", i), val_n[63:0], vt[i].n0);
            check($sformatf("v%0d.n_hazard", i), 64'(hazard_n), 64'(vt[i].hn));
            check($sformatf("v%0d.b_err", i), 64'(sb_err_b), 64'(vt[i].err));
            check($sformatf("v%0d.n_err", i), 64'(sb_err_n), 64'(vt[i].err));
        end

        // Overflow: four claims on rsp saturate at 3.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            idle();
            issue_valid = 1'b1;
            issue_dstE  = RRSP;
            issue_dstM  = RRSP;
        end
        @(negedge clock);
        idle();
        src  = {RNONE, RRSP};
        dstE = RRSP;
        valE = 64'h11;
        dstM = RRSP;
        valM = 64'h22;
        #1;
        check("sat.err_b", 64'(sb_err_b), 64'h1);
        check("sat.err_n", 64'(sb_err_n), 64'h1);
        check("sat.dec2_hazard", 64'(hazard_b[0]), 64'h1);
        @(negedge clock);
        idle();
        src  = {RNONE, RRSP};
        dstE = RRSP;
        valE = 64'h33;
        #1;
        check("sat.dec1_hazard_b", 64'(hazard_b[0]), 64'h0);
        check("sat.dec1_hazard_n", 64'(hazard_n[0]), 64'h1);
        check("sat.dec1_val_b", val_b[63:0], 64'h33);
        @(negedge clock);
        idle();
        src = {RNONE, RRSP};
        #1;
        check("sat.end_hazard_b", 64'(hazard_b[0]), 64'h0);
        check("sat.end_hazard_n", 64'(hazard_n[0]), 64'h0);
        check("sat.sticky_err", 64'(sb_err_b), 64'h1);
        check("sat.val_n", val_n[63:0], 64'h33);

        // Underflow: write with no outstanding claim.
        do_reset();
        #1;
        check("under.err_clr", 64'(sb_err_b), 64'h0);
        @(negedge clock);
        idle();
        dstE = RRSI;
        valE = 64'h66;
        #1;
        check("under.err_same_cycle", 64'(sb_err_b), 64'h0);
        @(negedge clock);
        idle();
        src = {RNONE, RRSI};
        #1;
        check("under.err_b", 64'(sb_err_b), 64'h1);
        check("under.err_n", 64'(sb_err_n), 64'h1);
        check("under.hazard", 64'(hazard_b), 64'h0);

        // Reset mid-operation, including an issue/retire net-zero cycle.
        do_reset();
        #1;
        check("mid.err_clr", 64'(sb_err_b), 64'h0);
        @(negedge clock);
        idle();
        issue_valid = 1'b1;
        issue_dstE  = RRAX;
        issue_dstM  = RRDI;
        @(negedge clock);
        idle();
        src         = {RRDI, RRAX};
        dstE        = RRAX;
        valE        = 64'h55;
        issue_valid = 1'b1;
        issue_dstE  = RRAX;
        #1;
        check("mid.retire_hazard_b", 64'(hazard_b), 64'h2);
        check("mid.retire_hazard_n", 64'(hazard_n), 64'h3);
        check("mid.retire_val_b", val_b[63:0], 64'h55);
        @(negedge clock);
        idle();
        src = {RRDI, RRAX};
        #1;
        check("mid.net0_hazard", 64'(hazard_b), 64'h3);
        check("mid.stored_val_n", val_n[63:0], 64'h55);
        check("mid.err", 64'(sb_err_b), 64'h0);
        @(negedge clock);
        idle();
        reset       = 1'b1;
        dstE        = RRAX;
        valE        = 64'hdead;
        issue_valid = 1'b1;
        issue_dstE  = RRBP;
        @(negedge clock);
        reset = 1'b0;
        idle();
        src = {RRBP, RRAX};
        #1;
        check("mid.rax_val", val_b[63:0], 64'h0);
        check("mid.rax_reg", regs_b[63:0], 64'h0);
        check("mid.rbp_hazard", 64'(hazard_b), 64'h0);
        check("mid.rsp_reg", regs_b[int'(RRSP)*64 +: 64], 64'h100);
        src = {RRDI, RRAX};
        #1;
        check("mid.rdi_hazard_b", 64'(hazard_b), 64'h0);
        check("mid.rdi_hazard_n", 64'(hazard_n), 64'h0);
        check("mid.stall", 64'(stall_b), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
